// File: rtl/sysbus_mem_responder.sv
// Sysbus memory target: accepts 8-beat line writes and reads against an internal store.
// Define SYSBUS_CRITICAL_WORD_FIRST_EN to return read beats starting at the addressed word.
module sysbus_mem_responder #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned IDX_W1 = IDX_W + 1;
    localparam int unsigned LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int unsigned LINE_W = BUS_DATA_WIDTH - 3;
    localparam logic [3:0]  DEV_MEM = 4'b0001;

    typedef enum logic [1:0] {IDLE, WDATA, LAT, RESP} state_t;

    // Word index base+k, wrapped into the store.
    function automatic logic [IDX_W-1:0] word_idx(input logic [IDX_W-1:0] base,
                                                  input logic [2:0]       k);
        logic [IDX_W1-1:0] sum;
        sum = {1'b0, base} + IDX_W1'(k);
        return IDX_W'(sum % IDX_W1'(MEM_WORDS));
    endfunction

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_t              state_q, state_d;
    logic [2:0]          beat_q, beat_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [IDX_W-1:0]    base_q, base_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
    logic                reqack_d, respcyc_d;
    logic [BUS_DATA_WIDTH-1:0] resp_d;
    logic [BUS_TAG_WIDTH-1:0]  resptag_d;
    logic [2:0]          crit_q, crit_d;

    logic [LINE_W-1:0]   line_word_c;
    logic [IDX_W-1:0]    base_c;
    logic                mem_we_c;
    logic [IDX_W-1:0]    mem_waddr_c;
    logic [2:0]          rd_beat_c, rd_off_c;
    logic [IDX_W-1:0]    rd_idx_c;
    logic [BUS_DATA_WIDTH-1:0] rd_word_c;

    assign line_word_c = {bus_req[BUS_DATA_WIDTH-1:6], 3'b000};
    assign base_c      = IDX_W'(line_word_c % LINE_W'(MEM_WORDS));
    assign mem_waddr_c = word_idx(base_q, beat_q);

    // In LAT the next word to present is beat 0; in RESP it is the following beat.
    assign rd_beat_c = (state_q == RESP) ? beat_q + 3'd1 : 3'd0;
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
    assign rd_off_c  = crit_q + rd_beat_c;
`else
    assign rd_off_c  = rd_beat_c;
`endif
    assign rd_idx_c  = word_idx(base_q, rd_off_c);
    assign rd_word_c = mem[rd_idx_c];

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        base_d    = base_q;
        tag_d     = tag_q;
        crit_d    = crit_q;
        reqack_d  = 1'b0;
        respcyc_d = bus_respcyc;
        resp_d    = bus_resp;
        resptag_d = bus_resptag;
        mem_we_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_reqcyc && (bus_reqtag[11:8] == DEV_MEM)) begin
                    reqack_d = 1'b1;
                    tag_d    = bus_reqtag;
                    base_d   = base_c;
                    crit_d   = bus_req[5:3];
                    beat_d   = 3'd0;
                    lat_d    = '0;
                    state_d  = bus_reqtag[12] ? LAT : WDATA;
                end
            end
            WDATA: begin
                if (bus_reqcyc) begin
                    mem_we_c = 1'b1;
                    if (beat_q == 3'd7) begin
                        beat_d  = 3'd0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            LAT: begin
                if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
                    lat_d     = '0;
                    state_d   = RESP;
                    respcyc_d = 1'b1;
                    resp_d    = rd_word_c;
                    resptag_d = tag_q;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RESP: begin
                if (bus_respack) begin
                    if (beat_q == 3'd7) begin
                        beat_d    = 3'd0;
                        state_d   = IDLE;
                        respcyc_d = 1'b0;
                        resp_d    = '0;
                        resptag_d = '0;
                    end else begin
                        beat_d = beat_q + 3'd1;
                        resp_d = rd_word_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            lat_q       <= '0;
            base_q      <= '0;
            tag_q       <= '0;
            crit_q      <= '0;
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            lat_q       <= lat_d;
            base_q      <= base_d;
            tag_q       <= tag_d;
            crit_q      <= crit_d;
            bus_reqack  <= reqack_d;
            bus_respcyc <= respcyc_d;
            bus_resp    <= resp_d;
            bus_resptag <= resptag_d;
        end
    end

    // Backing store survives reset; write enable is already gated by the state.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= bus_req;
        end
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: line write/read, stalls, foreign tags, resets.
module tb_sysbus_mem_responder;

    localparam int unsigned DW = 64;
    localparam int unsigned TW = 13;

    typedef logic [7:0][DW-1:0] line_t;

    logic          clk;
    logic          reset;
    logic          reqcyc;
    logic [DW-1:0] req;
    logic [TW-1:0] reqtag;
    logic          reqack;
    logic          respcyc;
    logic [DW-1:0] resp;
    logic [TW-1:0] resptag;
    logic          respack;

    int n_checks = 0;
    int n_fail   = 0;

    sysbus_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (reqcyc),
        .bus_req     (req),
        .bus_reqtag  (reqtag),
        .bus_reqack  (reqack),
        .bus_respcyc (respcyc),
        .bus_resp    (resp),
        .bus_resptag (resptag),
        .bus_respack (respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check_eq({name, "_reqack"},  64'(reqack),  64'd0);
        check_eq({name, "_respcyc"}, 64'(respcyc), 64'd0);
        check_eq({name, "_resp"},    resp,         64'd0);
        check_eq({name, "_resptag"}, 64'(resptag), 64'd0);
    endtask

    // Present a request and wait (bounded) for its ack; returns at the negedge showing ack.
    task automatic do_req(input logic [DW-1:0] addr, input logic [TW-1:0] tag);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        reqcyc = 1'b1;
        req    = addr;
        reqtag = tag;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = reqack;
        end
        check_eq("req_ack", 64'(seen), 64'd1);
    endtask

    task automatic wr_beats(input line_t d, input int n);
        for (int k = 0; k < n; k++) begin
            reqcyc = 1'b1;
            req    = d[k];
            @(negedge clk);
            check_eq("wdata_noack", 64'(reqack), 64'd0);
        end
        reqcyc = 1'b0;
        req    = '0;
    endtask

    task automatic rd_beats(input logic [TW-1:0] tag, input line_t exp,
                            input int stall_beat, input int stall_n, input int rst_beat);
        int lat;
        lat = 0;
        while (!respcyc && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("rd_latency", 64'(lat), 64'd4);
        for (int k = 0; k < 8; k++) begin
            check_eq("rd_valid", 64'(respcyc), 64'd1);
            check_eq("rd_data",  resp,         exp[k]);
            check_eq("rd_tag",   64'(resptag), 64'(tag));
            check_eq("rd_noack", 64'(reqack),  64'd0);
            if (k == rst_beat) begin
                reset = 1'b0;
                #1;
                check_idle_outputs("rst_async");
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            for (int s = 0; k == stall_beat && s < stall_n; s++) begin
                @(negedge clk);
                check_eq("stall_data",  resp,         exp[k]);
                check_eq("stall_valid", 64'(respcyc), 64'd1);
            end
            respack = 1'b1;
            @(negedge clk);
            respack = 1'b0;
        end
        check_idle_outputs("rd_end");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        line_t a, b, c, rot, mix;
        reset   = 1'b0;
        reqcyc  = 1'b0;
        req     = '0;
        reqtag  = '0;
        respack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a[k]   = 64'((k + 1) * 17);
            b[k]   = 64'(8'hB0 + k);
            c[k]   = 64'(8'hA0 + k);
            mix[k] = (k < 4) ? 64'(8'hA0 + k) : 64'(8'hB0 + k);
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
            rot[k] = 64'(((k + 3) % 8 + 1) * 17);
`else
            rot[k] = 64'((k + 1) * 17);
`endif
        end

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;

        // Basic line write then read back
        do_req(64'h1000, 13'h0100);
        wr_beats(a, 8);
        do_req(64'h1000, 13'h1100);
        reqcyc = 1'b0;
        rd_beats(13'h1100, a, -1, 0, -1);

        // Read with addr[5:3]=3
        do_req(64'h1018, 13'h1100);
        reqcyc = 1'b0;
        rd_beats(13'h1100, rot, -1, 0, -1);

        // Initiator stalls three cycles on beat 2
        do_req(64'h1000, 13'h1100);
        reqcyc = 1'b0;
        rd_beats(13'h1100, a, 2, 3, -1);

        // Foreign device type is ignored; a valid one right after is taken at once
        @(negedge clk);
        reqcyc = 1'b1;
        req    = 64'h1000;
        reqtag = 13'h1300;
        repeat (20) begin
            @(negedge clk);
            check_eq("foreign_noack",   64'(reqack),  64'd0);
            check_eq("foreign_respcyc", 64'(respcyc), 64'd0);
        end
        reqtag = 13'h1100;
        @(negedge clk);
        check_eq("idle_accept", 64'(reqack), 64'd1);
        reqcyc = 1'b0;
        rd_beats(13'h1100, a, -1, 0, -1);

        // Reset during beat 4 of a read, then a clean full read
        do_req(64'h1000, 13'h1100);
        reqcyc = 1'b0;
        rd_beats(13'h1100, a, -1, 0, 4);
        do_req(64'h1000, 13'h1100);
        reqcyc = 1'b0;
        rd_beats(13'h1100, a, -1, 0, -1);

        // Reset after four write beats keeps those beats only
        do_req(64'h2000, 13'h0100);
        wr_beats(b, 8);
        do_req(64'h2000, 13'h0105);
        wr_beats(c, 4);
        reset = 1'b0;
        #1;
        check_idle_outputs("rst_wdata");
        @(negedge clk);
        reset = 1'b1;
        do_req(64'h2000, 13'h1105);
        reqcyc = 1'b0;
        rd_beats(13'h1105, mix, -1, 0, -1);

        // Second request held through a read is acked once after IDLE return
        do_req(64'h1000, 13'h1100);
        req    = 64'h2000;
        reqtag = 13'h1105;
        rd_beats(13'h1100, a, -1, 0, -1);
        @(negedge clk);
        check_eq("held_ack", 64'(reqack), 64'd1);
        reqcyc = 1'b0;
        rd_beats(13'h1105, mix, -1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, bus data width in bits.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, bus tag width in bits.
REQ-003 SHALL have parameter MEM_WORDS, default 4096, depth of the backing store in BUS_DATA_WIDTH words.
REQ-004 SHALL have parameter READ_LATENCY, default 4, cycles from the accepted read request to the first response beat (minimum 1).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port bus_reqcyc, input, 1, initiator request valid.
REQ-008 SHALL have port bus_req, input, BUS_DATA_WIDTH, request address, or write data beat.
REQ-009 SHALL have port bus_reqtag, input, BUS_TAG_WIDTH, request tag: bit 12 = 1 read / 0 write; bits 11:8 = device type.
REQ-010 SHALL have port bus_reqack, output, 1, request accepted, one-cycle pulse.
REQ-011 SHALL have port bus_respcyc, output, 1, response beat valid.
REQ-012 SHALL have port bus_resp, output, BUS_DATA_WIDTH, response data beat.
REQ-013 SHALL have port bus_resptag, output, BUS_TAG_WIDTH, echo of the accepted request tag.
REQ-014 SHALL have port bus_respack, input, 1, initiator consumed the current response beat.

Function
REQ-015 SHALL implement FSM states IDLE, WDATA, LAT and RESP.
REQ-016 IDLE: when bus_reqcyc=1 and bus_reqtag[11:8]=4'b0001, SHALL assert bus_reqack for exactly one cycle, capture address and tag, and go to LAT for a read or WDATA for a write.
REQ-017 IDLE: SHALL ignore requests with any other device type (no ack, state unchanged).
REQ-018 Line = 8 beats (512 bits); line base word = (bus_req[63:6]*8) mod MEM_WORDS; word index SHALL wrap modulo MEM_WORDS.
REQ-019 WDATA: each cycle with bus_reqcyc=1 SHALL write bus_req to word base+k (k=0..7, incrementing); cycles with bus_reqcyc=0 stall k; after beat 7, return to IDLE; no response beats are issued for writes.
REQ-020 LAT: SHALL count READ_LATENCY cycles, then enter RESP with bus_respcyc=1 and beat 0 on bus_resp.
REQ-021 RESP: bus_resp SHALL hold the current beat's memory word; bus_resptag SHALL hold the captured tag.
REQ-022 RESP: a cycle with bus_respack=1 SHALL advance to the next beat; a cycle with bus_respack=0 SHALL hold data and valid unchanged.
REQ-023 RESP: respack on the 8th beat SHALL deassert bus_respcyc next cycle and return to IDLE.
REQ-024 SHALL not accept a new request outside IDLE; bus_reqack=0 in WDATA, LAT and RESP.
REQ-025 A request present in the same cycle as the IDLE return SHALL be acked no earlier than the next cycle.
REQ-026 bus_resp and bus_resptag SHALL be 0 whenever bus_respcyc=0.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0 and clear the beat and latency counters.
REQ-028 Reset SHALL not clear memory contents; reset mid-WDATA SHALL keep beats already written and drop the rest.
REQ-029 Reset mid-RESP SHALL abandon the transfer; after reset release, the first action SHALL be an IDLE accept.

Configuration
REQ-030 Macro SYSBUS_CRITICAL_WORD_FIRST_EN defined: read beat k SHALL return word base+((addr[5:3]+k) mod 8).
REQ-031 Macro SYSBUS_CRITICAL_WORD_FIRST_EN undefined: read beat k SHALL return word base+k, ignoring addr[5:3]; writes are unaffected in both builds.

Verification
REQ-032 Write to 0x1000 with tag 13'h0100 and beats 0x11..0x88, then read 0x1000 with tag 13'h1100 -> one ack each; first read beat 4 cycles after its ack; beats 0x11..0x88 in order; resptag=13'h1100.
REQ-033 With SYSBUS_CRITICAL_WORD_FIRST_EN, read of 0x1018 -> beats 0x44,0x55,0x66,0x77,0x88,0x11,0x22,0x33.
REQ-034 Read with respack held low 3 cycles on beat 2 -> bus_resp held at 0x33, respcyc=1 throughout; completes after beat 7.
REQ-035 Request with tag 13'h1300 -> no ack for 20 cycles; state IDLE.
REQ-036 reset=0 pulse during beat 4 of a read -> outputs 0 within the same cycle; a following read of 0x1000 returns the full line.
REQ-037 bus_reqcyc held during a read's LAT/RESP -> reqack stays 0 until IDLE, then the second request is acked once.
